// File: rtl/divider_pkg.sv
// Shared width defaults, id width helper and tag record layout for the divider arbiter.
package divider_pkg;

    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_DIVIDEND_WIDTH = 8;
    localparam int unsigned DEF_DIVIDER_WIDTH  = 8;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_ID_WIDTH = id_width(DEF_NUM_REQ);

    // Reference layout of one tag-line entry at the default widths.
    typedef struct packed {
        logic                          valid;
        logic [DEF_ID_WIDTH-1:0]       id;
        logic                          zero;
        logic [DEF_DIVIDEND_WIDTH-1:0] dividend;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just above last_grant and wraps.
module rr_arbiter
    import divider_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] above_mask;
    logic [NUM_REQ-1:0] req_hi;
    logic [NUM_REQ-1:0] pick;

    always_comb begin
        above_mask = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            above_mask[k] = (ID_W'(k) > last_grant);
        end
    end

    // Prefer requesters above the last winner, else wrap to the lowest one.
    assign req_hi = req & above_mask;
    assign pick   = (|req_hi) ? req_hi : req;
    assign grant  = pick & (~pick + NUM_REQ'(1));

endmodule

// File: rtl/divider_arbiter.sv
// Shares one fixed-latency divider pipeline among NUM_REQ requesters with tagged responses.
// Optional divide-by-zero handling is enabled by defining DIVIDER_ARB_ZERO_CHECK_EN.
module divider_arbiter
    import divider_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter  int unsigned DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter  int unsigned DIVIDER_WIDTH  = DEF_DIVIDER_WIDTH,
    parameter  int unsigned LATENCY        = DIVIDEND_WIDTH,
    localparam int unsigned ID_W           = id_width(NUM_REQ),
    localparam int unsigned INF_W          = $clog2(LATENCY + 1)
) (
    input  logic                              in_clk,
    input  logic                              in_rst,
    input  logic [NUM_REQ-1:0]                in_req_valid,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] in_req_dividend,
    input  logic [NUM_REQ*DIVIDER_WIDTH-1:0]  in_req_divider,
    output logic [NUM_REQ-1:0]                out_req_ready,
    output logic                              out_div_valid,
    output logic [DIVIDEND_WIDTH-1:0]         out_div_dividend,
    output logic [DIVIDER_WIDTH-1:0]          out_div_divider,
    input  logic                              in_div_valid,
    input  logic [DIVIDEND_WIDTH-1:0]         in_div_quotient,
    input  logic [DIVIDER_WIDTH-1:0]          in_div_remainder,
    output logic                              out_rsp_valid,
    output logic [ID_W-1:0]                   out_rsp_id,
    output logic [DIVIDEND_WIDTH-1:0]         out_rsp_quotient,
    output logic [DIVIDER_WIDTH-1:0]          out_rsp_remainder,
    output logic [INF_W-1:0]                  out_inflight,
    output logic                              out_err_sync
);

    localparam int unsigned CNT_W = (INF_W > 4) ? INF_W : 4;

    // Same field order as divider_pkg::tag_t, sized by this instance's parameters.
    typedef struct packed {
        logic                      valid;
        logic [ID_W-1:0]           id;
`ifdef DIVIDER_ARB_ZERO_CHECK_EN
        logic                      zero;
        logic [DIVIDEND_WIDTH-1:0] dividend;
`endif
    } tag_rec_t;

    logic [NUM_REQ-1:0] req_gated;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    win_id;
    logic               issue;
    tag_rec_t           tag_q [LATENCY];
    tag_rec_t           tag_d;
    tag_rec_t           tail;
    logic [INF_W-1:0]   inflight_q;
    logic [INF_W-1:0]   inflight_d;
    logic [CNT_W-1:0]   settle_q;
    logic               settled;
    logic               err_q;

    assign req_gated = in_rst ? '0 : in_req_valid;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_gated),
        .last_grant(last_grant_q),
        .grant     (grant)
    );

    always_comb begin
        win_id           = '0;
        out_div_dividend = '0;
        out_div_divider  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_id           = win_id | ID_W'(i);
                out_div_dividend = out_div_dividend | in_req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
                out_div_divider  = out_div_divider | in_req_divider[i*DIVIDER_WIDTH +: DIVIDER_WIDTH];
            end
        end
    end

    assign issue         = |grant;
    assign out_req_ready = grant;
    assign out_div_valid = issue;

    always_comb begin
        tag_d       = '0;
        tag_d.valid = issue;
        tag_d.id    = win_id;
`ifdef DIVIDER_ARB_ZERO_CHECK_EN
        tag_d.zero     = issue && (out_div_divider == '0);
        tag_d.dividend = out_div_dividend;
`endif
    end

    assign tail          = tag_q[LATENCY-1];
    assign settled       = (settle_q == '0);
    assign out_rsp_valid = ~in_rst & settled & tail.valid & in_div_valid;
    assign out_rsp_id    = tail.id;

`ifdef DIVIDER_ARB_ZERO_CHECK_EN
    always_comb begin
        out_rsp_quotient  = in_div_quotient;
        out_rsp_remainder = in_div_remainder;
        if (tail.zero) begin
            out_rsp_quotient  = '1;
            out_rsp_remainder = DIVIDER_WIDTH'(tail.dividend);
        end
    end
`else
    assign out_rsp_quotient  = in_div_quotient;
    assign out_rsp_remainder = in_div_remainder;
`endif

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, tail.valid})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            inflight_q <= '0;
            settle_q   <= CNT_W'(LATENCY);
            err_q      <= 1'b0;
        end else begin
            if (issue) begin
                last_grant_q <= win_id;
            end
            tag_q[0] <= tag_d;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            inflight_q <= inflight_d;
            if (!settled) begin
                settle_q <= settle_q - CNT_W'(1);
            end
            // Divider results still draining from before reset are ignored until settled.
            if (settled && (tail.valid != in_div_valid)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_inflight = in_rst ? '0 : inflight_q;
    assign out_err_sync = in_rst ? 1'b0 : err_q;

endmodule
